// File: rtl/lcd1602_custom_char_pkg.sv
// Shared constants and types for painting a 2x2 custom-glyph face on an HD44780 16x2 LCD.
package lcd1602_custom_char_pkg;

    localparam logic [7:0] CGRAM_BASE  = 8'h40;
    localparam logic [7:0] DDRAM_LINE1 = 8'h80;
    localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

    localparam int GLYPHS_PER_FACE = 4;
    localparam int ROWS_PER_GLYPH  = 8;
    localparam int CGRAM_ROWS      = GLYPHS_PER_FACE * ROWS_PER_GLYPH;
    localparam int TOTAL_STEPS     = 1 + CGRAM_ROWS + 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLACE
    } paint_state_e;

    typedef logic [5:0] step_t;

    // DDRAM placement writes after the CGRAM load, returned as {rs, data}.
    function automatic logic [8:0] placeWrite(input step_t step);
        case (step)
            6'd33:   return {1'b0, DDRAM_LINE1};
            6'd34:   return {1'b1, 8'h00};
            6'd35:   return {1'b1, 8'h01};
            6'd36:   return {1'b0, DDRAM_LINE2};
            6'd37:   return {1'b1, 8'h02};
            default: return {1'b1, 8'h03};
        endcase
    endfunction

endpackage

// File: rtl/lcd1602_face_rom.sv
// Combinational face ROM: (face, row) -> 5-bit glyph row; rows are glyph0..glyph3, 8 rows each.
module lcd1602_face_rom
    import lcd1602_custom_char_pkg::*;
#(
    parameter int NCW = 4
) (
    input  logic [NCW-1:0] face_i,
    input  logic [4:0]     row_i,
    output logic [4:0]     pattern_o
);

    localparam int FACES_DEFINED = 9;

    // Glyph order within a face: top-left, top-right, bottom-left, bottom-right.
    localparam logic [4:0] FACE_TABLE [FACES_DEFINED][CGRAM_ROWS] = '{
        '{5'h07, 5'h08, 5'h10, 5'h13, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h10, 5'h17, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h01, 5'h1D, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h13, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h14, 5'h13, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h05, 5'h19, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h13, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h13, 5'h14, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h19, 5'h05, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h13, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h11, 5'h12, 5'h12, 5'h11, 5'h08, 5'h07, 5'h00,  5'h01, 5'h11, 5'h09, 5'h09, 5'h11, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h10, 5'h17, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h14, 5'h13, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h05, 5'h19, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h14, 5'h1B, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h05, 5'h1B, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h13, 5'h14, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h19, 5'h05, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h10, 5'h17, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h01, 5'h1D, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h10, 5'h17, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h01, 5'h1D, 5'h01, 5'h02, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h10, 5'h13, 5'h13, 5'h10, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h01, 5'h19, 5'h19, 5'h01, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h10, 5'h17, 5'h11, 5'h09, 5'h07, 5'h00,  5'h01, 5'h01, 5'h01, 5'h1D, 5'h11, 5'h12, 5'h1C, 5'h00},
        '{5'h07, 5'h08, 5'h13, 5'h13, 5'h13, 5'h13, 5'h10, 5'h10,  5'h1C, 5'h02, 5'h19, 5'h19, 5'h19, 5'h19, 5'h01, 5'h01,
          5'h10, 5'h10, 5'h14, 5'h13, 5'h10, 5'h08, 5'h07, 5'h00,  5'h01, 5'h01, 5'h05, 5'h19, 5'h01, 5'h02, 5'h1C, 5'h00}
    };

    // Indices beyond the defined table fall back to the neutral face.
    always_comb begin
        pattern_o = FACE_TABLE[0][row_i];
        for (int f = 1; f < FACES_DEFINED; f++) begin
            if (32'(face_i) == f) begin
                pattern_o = FACE_TABLE[f][row_i];
            end
        end
    end

endmodule

// File: rtl/lcd1602_custom_char.sv
// Loads a selected 4-glyph face into CGRAM and places it as a 2x2 block at the left of the LCD.
module lcd1602_custom_char
#(
    parameter  int quantity_custom_char = 9,
    localparam int NCW = (quantity_custom_char > 1) ? $clog2(quantity_custom_char) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_16ms,
    input  logic [NCW-1:0] num_cust_char,
    input  logic           start_painting,
    output logic           lcd_available,
    output logic           rs,
    output logic           rw,
    output logic [7:0]     data
);
    import lcd1602_custom_char_pkg::*;

    logic         clk16Dly_q;
    logic         strobe;
    paint_state_e state_q, state_d;
    step_t        step_q, step_d;
    step_t        stepNext;
    logic [NCW-1:0] face_q, face_d;
    logic         rs_q, rs_d;
    logic         avail_q, avail_d;
    logic [7:0]   data_q, data_d;
    logic         faceValid;
    logic [4:0]   romPattern;
    logic [8:0]   placeWord;

    assign strobe    = clk_16ms & ~clk16Dly_q;
    assign stepNext  = step_q + 6'd1;
    assign faceValid = {1'b0, num_cust_char} < (NCW+1)'(quantity_custom_char);
    assign placeWord = placeWrite(stepNext);

    // The step about to be emitted is step_q+1, whose CGRAM row is step_q.
    lcd1602_face_rom #(.NCW(NCW)) u_face_rom (
        .face_i    (face_q),
        .row_i     (step_q[4:0]),
        .pattern_o (romPattern)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk16Dly_q <= 1'b0;
            state_q    <= IDLE;
            step_q     <= '0;
            face_q     <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            avail_q    <= 1'b1;
        end else begin
            clk16Dly_q <= clk_16ms;
            state_q    <= state_d;
            step_q     <= step_d;
            face_q     <= face_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            avail_q    <= avail_d;
        end
    end

    // Completion always lands in IDLE, so a still-high start needs a later strobe to repaint.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        face_d  = face_q;
        rs_d    = rs_q;
        data_d  = data_q;
        avail_d = avail_q;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    rs_d    = 1'b0;
                    data_d  = 8'h00;
                    avail_d = 1'b1;
                    if (start_painting) begin
                        face_d  = faceValid ? num_cust_char : '0;
                        step_d  = '0;
                        state_d = LOAD;
                        avail_d = 1'b0;
                        data_d  = CGRAM_BASE;
                    end
                end
                LOAD, PLACE: begin
                    if (step_q == step_t'(TOTAL_STEPS - 1)) begin
                        state_d = IDLE;
                        step_d  = '0;
                        rs_d    = 1'b0;
                        data_d  = 8'h00;
                        avail_d = 1'b1;
                    end else if (stepNext <= step_t'(CGRAM_ROWS)) begin
                        step_d  = stepNext;
                        state_d = LOAD;
                        rs_d    = 1'b1;
                        data_d  = {3'b000, romPattern};
                    end else begin
                        step_d  = stepNext;
                        state_d = PLACE;
                        {rs_d, data_d} = placeWord;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    rs_d    = 1'b0;
                    data_d  = 8'h00;
                    avail_d = 1'b1;
                end
            endcase
        end
    end

    assign lcd_available = avail_q;
    assign rs            = rs_q;
    assign rw            = 1'b0;
    assign data          = data_q;

endmodule

// File: tb/tb_lcd1602_custom_char.sv
// Directed bench for lcd1602_custom_char: reset, idle, face paints, retrigger and mid-paint reset.
module tb_lcd1602_custom_char;

    logic       clk;
    logic       reset;
    logic       clk_16ms;
    logic [3:0] num_cust_char;
    logic       start_painting;
    logic       lcd_available;
    logic       rs;
    logic       rw;
    logic [7:0] data;

    int total;
    int bad;

    localparam logic [10:0] IDLE_OUT = {1'b0, 1'b1, 1'b0, 8'h00};

    localparam logic [7:0] FACE0_ROWS [32] = '{
        8'h07, 8'h08, 8'h10, 8'h13, 8'h13, 8'h10, 8'h10, 8'h10,
        8'h1C, 8'h02, 8'h01, 8'h19, 8'h19, 8'h01, 8'h01, 8'h01,
        8'h10, 8'h10, 8'h10, 8'h17, 8'h10, 8'h08, 8'h07, 8'h00,
        8'h01, 8'h01, 8'h01, 8'h1D, 8'h01, 8'h02, 8'h1C, 8'h00};

    localparam logic [7:0] FACE3_ROWS [32] = '{
        8'h07, 8'h08, 8'h10, 8'h13, 8'h13, 8'h10, 8'h10, 8'h10,
        8'h1C, 8'h02, 8'h01, 8'h19, 8'h19, 8'h01, 8'h01, 8'h01,
        8'h10, 8'h11, 8'h12, 8'h12, 8'h11, 8'h08, 8'h07, 8'h00,
        8'h01, 8'h11, 8'h09, 8'h09, 8'h11, 8'h02, 8'h1C, 8'h00};

    lcd1602_custom_char #(.quantity_custom_char(9)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_16ms       (clk_16ms),
        .num_cust_char  (num_cust_char),
        .start_painting (start_painting),
        .lcd_available  (lcd_available),
        .rs             (rs),
        .rw             (rw),
        .data           (data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clk_16ms behaves like a register in the clk domain, toggling every 4 clk.
    initial begin
        clk_16ms = 1'b0;
        forever begin
            repeat (4) @(posedge clk);
            #1 clk_16ms = ~clk_16ms;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [3:0] num);
        start_painting = start;
        num_cust_char  = num;
    endtask

    task automatic waitStrobe();
        @(posedge clk_16ms);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [8:0] expectedWrite(input int face, input int step);
        if (step == 0)
            return {1'b0, 8'h40};
        else if (step <= 32)
            return {1'b1, (face == 3) ? FACE3_ROWS[step-1] : FACE0_ROWS[step-1]};
        case (step)
            33:      return {1'b0, 8'h80};
            34:      return {1'b1, 8'h00};
            35:      return {1'b1, 8'h01};
            36:      return {1'b0, 8'hC0};
            37:      return {1'b1, 8'h02};
            default: return {1'b1, 8'h03};
        endcase
    endfunction

    // Expects step 0 on the next strobe, all 39 writes, then the completion strobe.
    task automatic runPaint(input int face, input bit dropStart, input bit toggleNum);
        for (int step = 0; step < 39; step++) begin
            waitStrobe();
            checkOutput($sformatf("f%0d_w%0d", face, step), {21'd0, rw, lcd_available, rs, data},
                        {21'd0, 2'b00, expectedWrite(face, step)});
            if (dropStart && step == 1) start_painting = 1'b0;
            if (toggleNum && step == 10) num_cust_char = 4'd0;
            if (toggleNum && step == 20) num_cust_char = 4'd12;
        end
        waitStrobe();
        checkOutput($sformatf("f%0d_done", face), {21'd0, rw, lcd_available, rs, data}, {21'd0, IDLE_OUT});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0);

        for (int i = 0; i < 3; i++) begin
            waitStrobe();
            applyStimulus(1'b1, 4'd3);
            checkOutput("rst_avail", {31'd0, lcd_available}, 32'd1);
            checkOutput("rst_rs", {31'd0, rs}, 32'd0);
            checkOutput("rst_data", {24'd0, data}, 32'd0);
            checkOutput("rst_rw", {31'd0, rw}, 32'd0);
        end
        applyStimulus(1'b0, 4'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            waitStrobe();
            checkOutput($sformatf("idle%0d", i), {21'd0, rw, lcd_available, rs, data}, {21'd0, IDLE_OUT});
        end

        $display("[TB] paint face 3");
        applyStimulus(1'b1, 4'd3);
        runPaint(3, 1'b1, 1'b0);

        $display("[TB] paint out-of-range index 12");
        applyStimulus(1'b1, 4'd12);
        runPaint(0, 1'b1, 1'b0);

        $display("[TB] start held high across two paints");
        applyStimulus(1'b1, 4'd3);
        runPaint(3, 1'b0, 1'b1);
        runPaint(0, 1'b1, 1'b0);

        $display("[TB] reset during write 17");
        applyStimulus(1'b1, 4'd3);
        waitStrobe();
        checkOutput("pre_rst_w0", {23'd0, rs, data}, {23'd0, 9'h040});
        start_painting = 1'b0;
        for (int step = 1; step <= 17; step++) begin
            waitStrobe();
        end
        checkOutput("pre_rst_w17", {23'd0, rs, data}, {23'd0, expectedWrite(3, 17)});
        reset = 1'b0;
        #1;
        checkOutput("mid_rst", {21'd0, rw, lcd_available, rs, data}, {21'd0, IDLE_OUT});
        waitStrobe();
        checkOutput("mid_rst_hold", {21'd0, rw, lcd_available, rs, data}, {21'd0, IDLE_OUT});
        reset = 1'b1;
        waitStrobe();
        checkOutput("post_rst_idle", {21'd0, rw, lcd_available, rs, data}, {21'd0, IDLE_OUT});
        applyStimulus(1'b1, 4'd3);
        runPaint(3, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
